snow_mod_add_pipe: RTL and testbench

Pipelined, parametrised modulo-2^WIDTH multi-operand adder/subtractor with valid/ready flow control, for the SNOW 2.0 FSM and keystream datapath. It computes R1 + s15, (s5 ⊞ R2) ⊕ …, and similar word sums in one shared, back-pressurable unit. The result is always taken modulo 2^WIDTH. A wrap flag reports when the exact integer result fell outside [0, 2^WIDTH).

---
 rtl/snow_mod_add_pipe.sv | 98 +++++++++
 tb/tb_snow_mod_add_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snow_mod_add_pipe.sv
// snow_mod_add_pipe: two-stage, back-pressurable modulo-2^WIDTH multi-operand
// adder/subtractor. S1 holds operands and the sign mask. The adder tree sits
// between S1 and S2. S2 holds the reduced sum and the wrap flag.

// Sign-adjusts one operand into the widened internal domain.
module snow_mod_add_term #(
  parameter int WIDTH = 32,
  parameter int IW    = 34
) (
  input  logic [WIDTH-1:0] op,
  input  logic             neg,
  output logic [IW-1:0]    term
);
  logic [IW-1:0] ext;

  assign ext  = {{(IW-WIDTH){1'b0}}, op};
  assign term = neg ? (IW'(0) - ext) : ext;
endmodule

module snow_mod_add_pipe #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_OPS*WIDTH-1:0]   in_ops,
  input  logic [NUM_OPS-1:0]         in_neg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_sum,
  output logic                       out_wrap
);
  // Wide enough that NUM_OPS full-scale operands of either sign never overflow.
  localparam int IW = WIDTH + $clog2(NUM_OPS) + 1;

  // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied (out_valid)
  logic [2:1]                     vld_pipe;
  logic                           s1_adv, s2_adv;
  logic [NUM_OPS-1:0][WIDTH-1:0]  s1_ops;
  logic [NUM_OPS-1:0]             s1_neg;
  logic [NUM_OPS-1:0]             neg_eff;
  logic [NUM_OPS-1:0][IW-1:0]     terms;
  logic [IW-1:0]                  acc;
  logic                           wrap;

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe[2];

  // Operand 0 is always added regardless of its mask bit.
  assign neg_eff = s1_neg & ~NUM_OPS'(1);

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_term
    snow_mod_add_term #(.WIDTH(WIDTH), .IW(IW)) u_term (
      .op   (s1_ops[i]),
      .neg  (neg_eff[i]),
      .term (terms[i])
    );
  end

  // Exact signed sum of all sign-adjusted terms.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_OPS; i++) acc = acc + terms[i];
  end

  // Negative (sign bit) or any bit at or above 2^WIDTH means out of range.
  assign wrap = acc[IW-1] | (|acc[IW-2:WIDTH]);

  // S1 data capture on an input transfer; no reset needed for payload.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_ops <= in_ops;
      s1_neg <= in_neg;
    end
  end

  // Stage occupancy and S2 result registers; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      out_sum  <= '0;
      out_wrap <= 1'b0;
    end else begin
      if (s1_adv) vld_pipe[1] <= in_valid;
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_sum  <= acc[WIDTH-1:0];
          out_wrap <= wrap;
        end
      end
    end
  end
endmodule

// File: tb/tb_snow_mod_add_pipe.sv
// Bench for snow_mod_add_pipe: three configurations (32x2, 32x3, 8x4),
// directed boundary cases, random streaming / back-pressure with a queue
// scoreboard, and a mid-stream reset.
module tb_snow_mod_add_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT a: WIDTH=32, NUM_OPS=2
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_wrap;
  logic [63:0] a_in_ops;
  logic [1:0]  a_in_neg;
  logic [31:0] a_out_sum;
  // DUT b: WIDTH=32, NUM_OPS=3
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_wrap;
  logic [95:0] b_in_ops;
  logic [2:0]  b_in_neg;
  logic [31:0] b_out_sum;
  // DUT c: WIDTH=8, NUM_OPS=4
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_wrap;
  logic [31:0] c_in_ops;
  logic [3:0]  c_in_neg;
  logic [7:0]  c_out_sum;

  snow_mod_add_pipe #(.WIDTH(32), .NUM_OPS(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ops(a_in_ops), .in_neg(a_in_neg), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_sum(a_out_sum), .out_wrap(a_out_wrap));

  snow_mod_add_pipe #(.WIDTH(32), .NUM_OPS(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ops(b_in_ops), .in_neg(b_in_neg), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_sum(b_out_sum), .out_wrap(b_out_wrap));

  snow_mod_add_pipe #(.WIDTH(8), .NUM_OPS(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_ops(c_in_ops), .in_neg(c_in_neg), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_sum(c_out_sum), .out_wrap(c_out_wrap));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer sum, then reduce and classify.
  function automatic void ref_calc(input int w, input int n, input logic [255:0] flat,
                                   input logic [3:0] neg, output logic [63:0] sum,
                                   output logic wrap);
    longint e, v, mask;
    logic [255:0] sh;
    mask = (longint'(1) << w) - 1;
    e = 0;
    for (int i = 0; i < n; i++) begin
      sh = flat >> (i * w);
      v  = longint'(sh[63:0]) & mask;
      if (i > 0 && neg[i]) e = e - v;
      else                 e = e + v;
    end
    sum  = 64'(e & mask);
    wrap = (e < 0) || (e > mask);
  endfunction

  // ---------------- scoreboard for DUT a ----------------
  typedef struct packed { logic [31:0] sum; logic wrap; } res_t;
  res_t        q[$];
  res_t        r;
  logic        stall = 1'b0;
  logic [32:0] held;
  logic [63:0] m_sum;
  logic        m_wrap;
  int          a_out_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("a_hold_valid", 64'(a_out_valid), 64'd1);
        chk("a_hold_data", 64'({a_out_wrap, a_out_sum}), 64'(held));
      end
      if (a_in_valid && a_in_ready) begin
        ref_calc(32, 2, 256'(a_in_ops), {2'b00, a_in_neg}, m_sum, m_wrap);
        q.push_back({m_sum[31:0], m_wrap});
      end
      if (a_out_valid && a_out_ready) begin
        if (q.size() == 0) chk("a_no_stale", 64'(q.size()), 64'd1);
        else begin
          r = q.pop_front();
          chk("a_sb_sum", 64'(a_out_sum), 64'(r.sum));
          chk("a_sb_wrap", 64'(a_out_wrap), 64'(r.wrap));
        end
        a_out_cnt++;
      end
      stall = a_out_valid && !a_out_ready;
      held  = {a_out_wrap, a_out_sum};
    end
  end

  // One isolated transaction on a with latency check.
  task automatic a_dir(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [1:0] neg, input logic [31:0] es, input logic ew);
    @(posedge clk); #1;
    a_in_ops = {y, x}; a_in_neg = neg; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk); chk({tag, "_rdy"}, 64'(a_in_ready), 64'd1);
    @(posedge clk); #1; a_in_valid = 1'b0;
    @(negedge clk); chk({tag, "_lat1"}, 64'(a_out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, 64'(a_out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(a_out_sum), 64'(es));
    chk({tag, "_wrap"}, 64'(a_out_wrap), 64'(ew));
  endtask

  task automatic b_send(input string tag, input logic [95:0] ops, input logic [2:0] neg,
                        input logic [31:0] es, input logic ew);
    @(posedge clk); #1;
    b_in_ops = ops; b_in_neg = neg; b_in_valid = 1'b1;
    @(posedge clk); #1; b_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, 64'(b_out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(b_out_sum), 64'(es));
    chk({tag, "_wrap"}, 64'(b_out_wrap), 64'(ew));
  endtask

  task automatic c_send(input string tag, input logic [31:0] ops, input logic [3:0] neg,
                        input logic [7:0] es, input logic ew);
    @(posedge clk); #1;
    c_in_ops = ops; c_in_neg = neg; c_in_valid = 1'b1;
    @(posedge clk); #1; c_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, 64'(c_out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(c_out_sum), 64'(es));
    chk({tag, "_wrap"}, 64'(c_out_wrap), 64'(ew));
  endtask

  initial begin
    int acc_cnt, base;
    logic [63:0] es;
    logic        ew;
    logic [95:0] bops;
    logic [2:0]  bneg;
    logic [31:0] cops;
    logic [3:0]  cneg;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_ops = '0; a_in_neg = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_ops = '0; b_in_neg = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_ops = '0; c_in_neg = '0; c_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_vld", 64'(a_out_valid), 64'd0);
    chk("rst_a_sum", 64'(a_out_sum), 64'd0);
    chk("rst_a_wrap", 64'(a_out_wrap), 64'd0);
    chk("rst_c_vld", 64'(c_out_valid), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    #1 chk("rst_a_rdy", 64'(a_in_ready), 64'd1);

    // ---- directed, 32x2 ----
    a_dir("a_7fff", 32'h7FFFFFFF, 32'h1, 2'b00, 32'h80000000, 1'b0);
    a_dir("a_8000", 32'h80000000, 32'h80000000, 2'b00, 32'h0, 1'b1);
    a_dir("a_ffff2", 32'hFFFFFFFF, 32'h2, 2'b00, 32'h1, 1'b1);
    a_dir("a_ffff1", 32'hFFFFFFFF, 32'h1, 2'b00, 32'h0, 1'b1);
    a_dir("a_0m1", 32'h0, 32'h1, 2'b10, 32'hFFFFFFFF, 1'b1);
    a_dir("a_neg0", 32'h5, 32'h3, 2'b01, 32'h8, 1'b0);

    // ---- directed + random, 32x3 ----
    b_send("b_571", {32'd3, 32'd7, 32'd5}, 3'b010, 32'd1, 1'b0);
    b_send("b_010", {32'd0, 32'd1, 32'd0}, 3'b010, 32'hFFFFFFFF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bops = {$urandom, $urandom, $urandom};
      bneg = 3'($urandom);
      ref_calc(32, 3, 256'(bops), {1'b0, bneg}, es, ew);
      b_send("b_rnd", bops, bneg, es[31:0], ew);
    end

    // ---- directed + random, 8x4 ----
    c_send("c_ff0", 32'hFFFFFFFF, 4'b0000, 8'hFC, 1'b1);
    c_send("c_ffE", 32'hFFFFFFFF, 4'b1110, 8'h02, 1'b1);
    c_send("c_ff1", 32'hFFFFFFFF, 4'b0001, 8'hFC, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cops = $urandom;
      cneg = 4'($urandom);
      ref_calc(8, 4, 256'(cops), cneg, es, ew);
      c_send("c_rnd", cops, cneg, es[7:0], ew);
    end

    // ---- streaming, 100 back-to-back ----
    base = a_out_cnt;
    a_out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1; a_in_ops = {$urandom, $urandom}; a_in_neg = 2'($urandom);
    end
    @(posedge clk); #1; a_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("a_stream_cnt", 64'(a_out_cnt - base), 64'd100);

    // ---- back-pressure: capacity two ----
    @(posedge clk); #1;
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      a_in_ops = {$urandom, $urandom}; a_in_neg = 2'($urandom);
      @(negedge clk);
      if (a_in_valid && a_in_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    chk("a_bp_accepts", 64'(acc_cnt), 64'd2);
    chk("a_bp_rdy0", 64'(a_in_ready), 64'd0);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    #1 chk("a_bp_rdy_comb", 64'(a_in_ready), 64'd1);
    repeat (4) @(posedge clk);

    // ---- random back-pressure, 500 cycles ----
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      a_in_valid  = 1'($urandom);
      a_out_ready = 1'($urandom);
      a_in_ops    = {$urandom, $urandom};
      a_in_neg    = 2'($urandom);
    end
    @(posedge clk); #1; a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    chk("a_drain", 64'(q.size()), 64'd0);

    // ---- mid-stream reset with two in flight ----
    @(posedge clk); #1;
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_ops = {32'h1234, 32'h5678}; a_in_neg = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; a_in_valid = 1'b0;
    chk("a_rst_vld", 64'(a_out_valid), 64'd0);
    chk("a_rst_sum", 64'(a_out_sum), 64'd0);
    chk("a_rst_wrap", 64'(a_out_wrap), 64'd0);
    chk("a_rst_rdy", 64'(a_in_ready), 64'd1);
    base = a_out_cnt;
    a_out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    chk("a_rst_nostale", 64'(a_out_cnt - base), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
